// File: rtl/uart_rx_cfg.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : uart_rx_cfg
//  Purpose  : Configurable UART receiver. Supports 5-9 data bits, none/odd/
//             even parity and 1 or 2 stop bits. Bit timing comes from a
//             fractional NCO oversampling tick. Each bit is resolved by a
//             3-sample majority vote at mid-bit. Break frames are detected
//             and then locked out. Received words are queued in a FWFT FIFO
//             and drained over a valid/ready stream.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             rx_i              - asynchronous serial input, idle high
//             m_data/m_perr/
//             m_ferr/m_valid/
//             m_ready           - FIFO head stream (LSB = first bit received)
//             overrun           - pulse: completed frame dropped, FIFO full
//             break_det         - pulse: break condition detected
//             busy              - receiver not idle (includes break lockout)
//             fifo_level        - current FIFO occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_cfg #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int ACC_W      = 24,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_i,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          m_perr,
  output logic                          m_ferr,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          overrun,
  output logic                          break_det,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BC_W  = 4;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = DATA_BITS + 2;

  // Rounded NCO increment: BAUD*OVERSAMPLE*2^ACC_W / CLK_HZ, in 64-bit.
  localparam logic [63:0] c_INCR =
    (((64'(BAUD) * 64'(OVERSAMPLE)) << ACC_W) + (64'(CLK_HZ) / 64'd2)) / 64'(CLK_HZ);
  localparam logic [ACC_W:0] c_INCR_W = c_INCR[ACC_W:0];

  localparam logic [OS_W-1:0] c_H_M1   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] c_H      = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0] c_H_P1   = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [OS_W-1:0] c_OS_MAX = OS_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] c_LAST_DATA = BC_W'(DATA_BITS - 1);
  localparam logic [BC_W-1:0] c_LAST_STOP = BC_W'(STOP_BITS - 1);
  localparam logic            c_ODD    = (PARITY == 1);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_START  = 3'd1;
  localparam logic [2:0] c_DATA   = 3'd2;
  localparam logic [2:0] c_PARITY = 3'd3;
  localparam logic [2:0] c_STOP   = 3'd4;
  localparam logic [2:0] c_LOCK   = 3'd5;

  // Elaboration-time sanity checks.
  generate
    if (c_INCR == 64'd0 || c_INCR >= (64'd1 << ACC_W)) begin : g_incr_chk
      $error("uart_rx_cfg: NCO increment out of range for CLK_HZ/BAUD/OVERSAMPLE/ACC_W");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_chk
      $error("uart_rx_cfg: illegal parameter combination");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Input synchronizer and NCO tick
  // --------------------------------------------------------------------------
  logic             rx_meta_q, rx_sync_q;
  logic [ACC_W-1:0] phase_q;
  logic             tick_q;
  logic [ACC_W:0]   w_sum;

  assign w_sum = {1'b0, phase_q} + c_INCR_W;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      phase_q   <= '0;
      tick_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      phase_q   <= w_sum[ACC_W-1:0];
      tick_q    <= w_sum[ACC_W];
    end
  end

  // --------------------------------------------------------------------------
  // Receive FSM
  // --------------------------------------------------------------------------
  logic [2:0]           state_q,   state_d;
  logic [OS_W-1:0]      os_cnt_q,  os_cnt_d;
  logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
  // Two previous mid-bit samples; together with the live sample they form
  // the 3-sample vote, so the decision lands on the third sample tick.
  logic [1:0]           vote_q,    vote_d;
  logic [DATA_BITS-1:0] data_q,    data_d;
  logic                 perr_q,    perr_d;
  logic                 ferr_q,    ferr_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop0_q,   stop0_d;
  logic                 push_q,    push_d;
  logic                 brk_q,     brk_d;

  logic [2:0]      w_vote_now;
  logic            w_maj;
  logic            w_samp_pt;
  logic            w_decide;
  logic [OS_W-1:0] w_os_inc;
  logic            w_first_stop;
  logic            w_break;

  assign w_vote_now = {vote_q, rx_sync_q};
  assign w_maj      = (w_vote_now[2] & w_vote_now[1]) | (w_vote_now[2] & w_vote_now[0]) |
                      (w_vote_now[1] & w_vote_now[0]);
  assign w_samp_pt  = (os_cnt_q == c_H_M1) || (os_cnt_q == c_H) || (os_cnt_q == c_H_P1);
  assign w_decide   = (os_cnt_q == c_H_P1);
  assign w_os_inc   = (os_cnt_q == c_OS_MAX) ? '0 : os_cnt_q + OS_W'(1);
  // With one stop bit the first stop value is the one being decided now.
  assign w_first_stop = (bit_cnt_q == '0) ? w_maj : stop0_q;
  // par_bit_q stays 0 when parity is disabled, so it drops out of the test.
  assign w_break      = ~|data_q & ~par_bit_q & ~w_first_stop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= c_IDLE;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      vote_q    <= 2'b11;
      data_q    <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      par_bit_q <= 1'b0;
      stop0_q   <= 1'b1;
      push_q    <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      vote_q    <= vote_d;
      data_q    <= data_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      par_bit_q <= par_bit_d;
      stop0_q   <= stop0_d;
      push_q    <= push_d;
      brk_q     <= brk_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_cnt_d = bit_cnt_q;
    vote_d    = vote_q;
    data_d    = data_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    par_bit_d = par_bit_q;
    stop0_d   = stop0_q;
    push_d    = 1'b0;
    brk_d     = 1'b0;
    if (tick_q) begin
      case (state_q)
        c_IDLE: begin
          if (!rx_sync_q) begin
            state_d   = c_START;
            os_cnt_d  = '0;
            perr_d    = 1'b0;
            ferr_d    = 1'b0;
            par_bit_d = 1'b0;
            stop0_d   = 1'b1;
          end
        end
        c_LOCK: begin
          // Leave only after OVERSAMPLE consecutive high ticks.
          if (!rx_sync_q) begin
            os_cnt_d = '0;
          end else if (os_cnt_q == c_OS_MAX) begin
            state_d  = c_IDLE;
            os_cnt_d = '0;
          end else begin
            os_cnt_d = os_cnt_q + OS_W'(1);
          end
        end
        default: begin
          os_cnt_d = w_os_inc;
          if (w_samp_pt) begin
            vote_d = w_vote_now[1:0];
          end
          if (w_decide) begin
            case (state_q)
              c_START: begin
                if (w_maj) begin
                  state_d = c_IDLE;
                end else begin
                  state_d   = c_DATA;
                  bit_cnt_d = '0;
                end
              end
              c_DATA: begin
                data_d = {w_maj, data_q[DATA_BITS-1:1]};
                if (bit_cnt_q == c_LAST_DATA) begin
                  bit_cnt_d = '0;
                  state_d   = (PARITY != 0) ? c_PARITY : c_STOP;
                end else begin
                  bit_cnt_d = bit_cnt_q + BC_W'(1);
                end
              end
              c_PARITY: begin
                par_bit_d = w_maj;
                perr_d    = ((^data_q) ^ w_maj) != c_ODD;
                state_d   = c_STOP;
              end
              c_STOP: begin
                if (!w_maj) begin
                  ferr_d = 1'b1;
                end
                if (bit_cnt_q == '0) begin
                  stop0_d = w_maj;
                end
                if (bit_cnt_q == c_LAST_STOP) begin
                  bit_cnt_d = '0;
                  // Return at mid-bit: half a bit of margin to resync.
                  if (w_break) begin
                    brk_d    = 1'b1;
                    state_d  = c_LOCK;
                    os_cnt_d = '0;
                  end else begin
                    push_d  = 1'b1;
                    state_d = c_IDLE;
                  end
                end else begin
                  bit_cnt_d = bit_cnt_q + BC_W'(1);
                end
              end
              default: state_d = c_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  always_comb begin
    busy      = (state_q != c_IDLE);
    break_det = brk_q;
  end

  // --------------------------------------------------------------------------
  // FWFT receive FIFO
  // --------------------------------------------------------------------------
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             ovr_q;
  logic             w_full, w_pop, w_wr;
  logic [ENT_W-1:0] w_head;

  assign w_full = (count_q == CNT_W'(FIFO_DEPTH));
  assign w_pop  = m_valid & m_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_wr   = push_q & (~w_full | w_pop);
  assign w_head = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      mem_q[wr_ptr_q] <= {data_q, perr_q, ferr_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      ovr_q <= push_q & w_full & ~w_pop;
      if (w_wr) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign m_valid    = (count_q != '0);
  assign {m_data, m_perr, m_ferr} = m_valid ? w_head : '0;
  assign overrun    = ovr_q;
  assign fifo_level = count_q;

endmodule
`default_nettype wire
